// File: rtl/uart_rx_parity.sv
// UART receiver: 8 data bits LSB first, optional parity, one stop bit.
// Reports rdy, parity, framing and overrun status until rdy_clr acknowledges the byte.
module uart_rx_parity #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          par_bit;

  // Synchronizer, receive FSM and status flags; a completion outranks rdy_clr.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sync1      <= 1'b1;
      rxs        <= 1'b1;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      dout       <= '0;
      rdy        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;

      if (rdy_clr) begin
        rdy        <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rxs) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= PAR_EN ? S_PARITY : S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            par_bit <= rxs;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt        <= '0;
            dout       <= shreg;
            rdy        <= 1'b1;
            frame_err  <= ~rxs;
            parity_err <= PAR_EN ? (^{shreg, par_bit, PAR_ODD}) : 1'b0;
            overrun    <= rdy & ~rdy_clr;
            state      <= rxs ? S_IDLE : S_BREAK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rxs) state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity at 16 clocks per bit, even parity.
module tb_uart_rx_parity;

  logic       clock;
  logic       reset;
  logic       rx;
  logic       rdy_clr;
  logic [7:0] dout;
  logic       rdy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int checks;
  int failures;

  uart_rx_parity #(
    .CLKS_PER_BIT(16),
    .PARITY_EN(1),
    .PARITY_ODD(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .rdy_clr(rdy_clr),
    .dout(dout),
    .rdy(rdy),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one 11-bit frame; rdy_clr is sampled high at edge clr_at; returns edge of rdy rise.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int clr_at, output int rise_at);
    logic [10:0] seq;
    logic        prev;
    int          e;
    seq     = {stop, par, data, 1'b0};
    rise_at = -1;
    e       = 0;
    @(posedge clock); #1;
    prev = rdy;
    for (int b = 0; b < 11; b++) begin
      rx = seq[b];
      for (int c = 0; c < 16; c++) begin
        @(posedge clock); #1;
        e++;
        rdy_clr = (e == clr_at - 1);
        if (rise_at < 0 && rdy && !prev) rise_at = e;
        prev = rdy;
      end
    end
    rdy_clr = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clock); #1;
    rdy_clr = 1'b1;
    @(posedge clock); #1;
    rdy_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; rdy_clr = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({dout, rdy, parity_err, frame_err, overrun} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got dout=%h rdy=%b pe=%b fe=%b ov=%b, want all 0",
               dout, rdy, parity_err, frame_err, overrun);
    end
    reset = 1'b0;
    repeat (5) @(posedge clock);
  endtask

  task automatic test_good_frame();
    int r;
    send_frame(8'h54, 1'b1, 1'b1, -1, r);
    rx = 1'b1;
    checks++;
    if (r !== 171) begin
      failures++; $display("FAIL latency: got %0d want 171", r);
    end
    checks++;
    if ({rdy, dout, parity_err, frame_err, overrun} !== {1'b1, 8'h54, 3'b000}) begin
      failures++;
      $display("FAIL good_frame: got rdy=%b dout=%h pe=%b fe=%b ov=%b, want 1 54 0 0 0",
               rdy, dout, parity_err, frame_err, overrun);
    end
    pulse_clr();
  endtask

  task automatic test_parity_error();
    int r;
    send_frame(8'h54, 1'b0, 1'b1, -1, r);
    rx = 1'b1;
    checks++;
    if ({rdy, dout, parity_err, frame_err} !== {1'b1, 8'h54, 2'b10}) begin
      failures++;
      $display("FAIL parity_err_set: got rdy=%b dout=%h pe=%b fe=%b, want 1 54 1 0",
               rdy, dout, parity_err, frame_err);
    end
    rdy_clr = 1'b1;
    @(posedge clock); #1;
    rdy_clr = 1'b0;
    checks++;
    if ({rdy, parity_err} !== 2'b00) begin
      failures++;
      $display("FAIL parity_err_clear: got rdy=%b pe=%b, want 0 0", rdy, parity_err);
    end
  endtask

  task automatic test_break();
    int  r;
    logic seen;
    send_frame(8'hA5, 1'b0, 1'b0, -1, r);
    checks++;
    if ({rdy, dout, parity_err, frame_err} !== {1'b1, 8'hA5, 2'b01}) begin
      failures++;
      $display("FAIL frame_err_set: got rdy=%b dout=%h pe=%b fe=%b, want 1 a5 0 1",
               rdy, dout, parity_err, frame_err);
    end
    pulse_clr();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (rdy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL break_hold: got rdy during break=%b want 0", seen);
    end
    rx = 1'b1;
    repeat (20) @(posedge clock);
    send_frame(8'h01, 1'b1, 1'b1, -1, r);
    rx = 1'b1;
    checks++;
    if ({rdy, dout, parity_err, frame_err} !== {1'b1, 8'h01, 2'b00}) begin
      failures++;
      $display("FAIL after_break: got rdy=%b dout=%h pe=%b fe=%b, want 1 01 0 0",
               rdy, dout, parity_err, frame_err);
    end
    pulse_clr();
  endtask

  task automatic test_glitch();
    int   r;
    logic seen;
    @(posedge clock); #1;
    rx = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock); #1;
      if (rdy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL glitch_reject: got rdy=%b want 0", seen);
    end
    send_frame(8'h3C, 1'b0, 1'b1, -1, r);
    rx = 1'b1;
    checks++;
    if ({rdy, dout, parity_err, frame_err} !== {1'b1, 8'h3C, 2'b00}) begin
      failures++;
      $display("FAIL after_glitch: got rdy=%b dout=%h pe=%b fe=%b, want 1 3c 0 0",
               rdy, dout, parity_err, frame_err);
    end
    pulse_clr();
  endtask

  task automatic test_back_to_back();
    int r;
    send_frame(8'h11, 1'b0, 1'b1, -1, r);
    send_frame(8'h22, 1'b0, 1'b1, -1, r);
    rx = 1'b1;
    checks++;
    if ({rdy, dout, overrun} !== {1'b1, 8'h22, 1'b1}) begin
      failures++;
      $display("FAIL overrun_set: got rdy=%b dout=%h ov=%b, want 1 22 1", rdy, dout, overrun);
    end
    pulse_clr();
    send_frame(8'h11, 1'b0, 1'b1, -1, r);
    send_frame(8'h22, 1'b0, 1'b1, 171, r);
    rx = 1'b1;
    checks++;
    if ({rdy, dout, overrun, parity_err} !== {1'b1, 8'h22, 2'b00}) begin
      failures++;
      $display("FAIL clr_same_cycle: got rdy=%b dout=%h ov=%b pe=%b, want 1 22 0 0",
               rdy, dout, overrun, parity_err);
    end
    pulse_clr();
  endtask

  task automatic test_reset_midframe();
    int   r;
    logic seen;
    @(posedge clock); #1;
    rx = 1'b0;
    repeat (16) @(posedge clock);
    #1;
    rx = 1'b1;
    repeat (72) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({dout, rdy, parity_err, frame_err, overrun} !== 12'h000) begin
      failures++;
      $display("FAIL async_reset: got dout=%h rdy=%b pe=%b fe=%b ov=%b, want all 0",
               dout, rdy, parity_err, frame_err, overrun);
    end
    repeat (3) @(posedge clock);
    #1;
    rx = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clock); #1;
      if (rdy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || {dout, rdy, parity_err, frame_err, overrun} !== 12'h000) begin
      failures++;
      $display("FAIL aborted_frame: got seen_rdy=%b dout=%h pe=%b fe=%b ov=%b, want 0 00 0 0 0",
               seen, dout, parity_err, frame_err, overrun);
    end
    send_frame(8'h80, 1'b1, 1'b1, -1, r);
    rx = 1'b1;
    checks++;
    if ({rdy, dout, parity_err, frame_err, overrun} !== {1'b1, 8'h80, 3'b000}) begin
      failures++;
      $display("FAIL after_reset: got rdy=%b dout=%h pe=%b fe=%b ov=%b, want 1 80 0 0 0",
               rdy, dout, parity_err, frame_err, overrun);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_good_frame();
    test_parity_error();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity.md
UART_RX_PARITY -- requirements
Module: uart_rx_parity

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit; legal values are 8 and above.
REQ-002 The block SHALL have parameter PARITY_EN, default 1, where 1 means a parity bit follows the data bits.
REQ-003 The block SHALL have parameter PARITY_ODD, default 0, where 0 means even parity and 1 means odd parity.
REQ-004 Port: clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: rx  input  1  asynchronous serial line; idles high.
REQ-007 Port: rdy_clr  input  1  consumer acknowledge; clears rdy and the error flags.
REQ-008 Port: dout  output  8  last received data byte; dout[0] is the first data bit received (LSB-first line order).
REQ-009 Port: rdy  output  1  a completed byte is available on dout.
REQ-010 Port: parity_err  output  1  the byte on dout failed its parity check.
REQ-011 Port: frame_err  output  1  the byte on dout had a low stop bit.
REQ-012 Port: overrun  output  1  a byte completed while rdy was still high.

Function
REQ-013 rx SHALL pass through a two-flop synchronizer, and all decisions SHALL use the synchronized value rxs.
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP and BREAK, with one bit counter (0..CLKS_PER_BIT-1) and one bit index (0..7).
- IDLE: if rxs==0, go to START with counter=0.
- START: at counter==CLKS_PER_BIT/2-1, go to DATA with counter=0 if rxs==0; otherwise return to IDLE (glitch reject).
- DATA: at counter==CLKS_PER_BIT-1, shift rxs into bit[index] and reset the counter. After index 7, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: at counter==CLKS_PER_BIT-1, sample the parity bit and go to STOP.
- STOP: at counter==CLKS_PER_BIT-1, sample the stop bit and complete the byte. Go to IDLE if the stop bit is 1, or to BREAK if it is 0.
- BREAK: remain until rxs==1, then go to IDLE; no new start bit is accepted while in BREAK.
REQ-015 The bit sampling point SHALL be mid-bit, because START ends at the half-bit point and every later sample is a full bit period after it.
REQ-016 On byte completion, in the cycle after the stop sample, the block SHALL do all of the following in the same edge:
- load dout with the shifted byte;
- set rdy=1;
- set frame_err to the inverse of the stop bit;
- set parity_err to (XOR of the 8 data bits, the parity bit and PARITY_ODD) != 0 when PARITY_EN=1, and to 0 otherwise.
REQ-017 If rdy is already 1 at byte completion, the block SHALL overwrite dout and the error flags and set overrun=1.
REQ-018 rdy, parity_err, frame_err and overrun SHALL hold their values until rdy_clr is sampled high, which clears all four on the next edge.
REQ-019 If rdy_clr is high in the same cycle as a byte completion, the completion SHALL win: rdy=1 with the new flags, and overrun=0 because the old byte was acknowledged.
REQ-020 rdy_clr SHALL NOT affect the receive state machine, and reception SHALL continue regardless of rdy.
REQ-021 End-to-end latency SHALL be 2 synchronizer cycles plus (CLKS_PER_BIT/2 + (9+PARITY_EN)*CLKS_PER_BIT) cycles plus 1 cycle, measured from the rx falling edge to rdy rising.
REQ-022 The counter SHALL wrap only through the explicit compare in REQ-014 and SHALL never count past CLKS_PER_BIT-1.

Reset
REQ-023 When reset is asserted, the block SHALL asynchronously force state=IDLE, counter=0, index=0, dout=0x00, rdy=0, parity_err=0, frame_err=0, overrun=0, and set both synchronizer flops to 1.
REQ-024 A reset asserted mid-frame SHALL discard the partial byte. After release, the block SHALL wait for a new falling edge, and no rdy SHALL be produced from the aborted frame.

Verification (bench uses CLKS_PER_BIT=16, PARITY_EN=1, PARITY_ODD=0)
REQ-025 Send frame 0x54 with even parity bit 1 and stop 1 -> rdy rises exactly 2+8+160+1=171 cycles after the start edge, dout=0x54, parity_err=0, frame_err=0.
REQ-026 Send 0x54 with parity bit 0 -> rdy=1, dout=0x54, parity_err=1. Then pulse rdy_clr -> rdy=0 and parity_err=0 on the next edge.
REQ-027 Send 0xA5 with stop bit 0, holding rx low for 40 further cycles -> frame_err=1 and state stays BREAK until rx goes high. A following frame 0x01 is then received correctly.
REQ-028 Pulse rx low for 5 cycles, then high -> no rdy, state returns to IDLE, and a subsequent 0x3C frame is received correctly.
REQ-029 Send 0x11 then 0x22 back-to-back without rdy_clr -> dout=0x22 and overrun=1. A rdy_clr in the completion cycle of the second byte instead gives overrun=0 and rdy=1.
REQ-030 Assert reset during data bit 4 of 0xFF and release it while rx is low -> rdy stays 0 and all outputs are 0. The next full 0x80 frame yields dout=0x80.
